// File: rtl/move_sequencer.sv
// move_sequencer: per-frame sprite motion; proposes x then y moves to an external
// collision checker over a valid/ack probe and commits the accepted position.
module move_sequencer #(
    parameter int X_INIT = 40,
    parameter int Y_INIT = 400,
    parameter int X_MAX  = 619,
    parameter int Y_MAX  = 459,
    parameter int STEP_X = 2,
    parameter int JUMP_V = 8,
    parameter int VMAX   = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       frame_tick,
    input  logic [3:0] wsad_down,
    input  logic       restart,
    output logic       probe_valid,
    output logic [9:0] probe_x,
    output logic [8:0] probe_y,
    input  logic       probe_ack,
    input  logic [1:0] collision_state,
    output logic [9:0] x_blue,
    output logic [8:0] y_blue,
    output logic [2:0] blue_state,
    output logic       update_done,
    output logic       overrun
);
    localparam logic signed [4:0]  JV = 5'(JUMP_V);
    localparam logic signed [4:0]  VM = 5'(VMAX);
    localparam logic signed [10:0] XM = 11'(X_MAX);
    localparam logic signed [10:0] YM = 11'(Y_MAX);
    localparam logic signed [10:0] SX = 11'(STEP_X);

    typedef enum logic [2:0] {IDLE, PROBE_X, PROBE_Y, COMMIT, DEAD, WIN} state_t;
    state_t state;

    logic signed [4:0]  vy, vy_n;
    logic signed [10:0] x_sum, y_sum;
    logic [9:0] x_acc, x_cand, x_next;
    logic [8:0] y_acc, y_cand, y_next;
    logic grounded, goal, need_y, dir_l, dir_r;
    logic go_l, go_r, need_x, need_y_n, unused_s;

    assign unused_s = wsad_down[2];

    always_comb begin
        go_r     = wsad_down[0] & ~wsad_down[1];
        go_l     = wsad_down[1] & ~wsad_down[0];
        vy_n     = (wsad_down[3] && grounded) ? -JV : (vy < VM) ? vy + 5'sd1 : VM;
        x_sum    = $signed({1'b0, x_blue}) + (go_r ? SX : go_l ? -SX : 11'sd0);
        y_sum    = $signed({2'b00, y_blue}) + $signed({{6{vy_n[4]}}, vy_n});
        x_next   = x_sum < 11'sd0 ? 10'd0 : x_sum > XM ? XM[9:0] : x_sum[9:0];
        y_next   = y_sum < 11'sd0 ? 9'd0 : y_sum > YM ? YM[8:0] : y_sum[8:0];
        need_x   = x_next != x_blue;
        need_y_n = vy_n != 5'sd0 && y_next != y_blue;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            x_blue      <= 10'(X_INIT);
            y_blue      <= 9'(Y_INIT);
            blue_state  <= 3'd0;
            vy          <= 5'sd0;
            grounded    <= 1'b1;
            goal        <= 1'b0;
            need_y      <= 1'b0;
            dir_l       <= 1'b0;
            dir_r       <= 1'b0;
            x_acc       <= '0;
            y_acc       <= '0;
            x_cand      <= '0;
            y_cand      <= '0;
            probe_valid <= 1'b0;
            probe_x     <= '0;
            probe_y     <= '0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else if (restart) begin
            state       <= IDLE;
            x_blue      <= 10'(X_INIT);
            y_blue      <= 9'(Y_INIT);
            blue_state  <= 3'd0;
            vy          <= 5'sd0;
            grounded    <= 1'b1;
            probe_valid <= 1'b0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (frame_tick && (state == PROBE_X || state == PROBE_Y || state == COMMIT))
                overrun <= 1'b1;
            case (state)
                IDLE: if (frame_tick) begin
                    vy          <= vy_n;
                    x_cand      <= x_next;
                    y_cand      <= y_next;
                    x_acc       <= x_blue;
                    y_acc       <= y_blue;
                    goal        <= 1'b0;
                    need_y      <= need_y_n;
                    dir_l       <= go_l;
                    dir_r       <= go_r;
                    probe_valid <= need_x || need_y_n;
                    probe_x     <= need_x ? x_next : x_blue;
                    probe_y     <= need_x ? y_blue : y_next;
                    state       <= need_x ? PROBE_X : need_y_n ? PROBE_Y : COMMIT;
                end
                PROBE_X: if (probe_valid && probe_ack) begin
                    probe_valid <= 1'b0;
                    if (collision_state == 2'b10) begin
                        state      <= DEAD;
                        blue_state <= 3'd5;
                    end else begin
                        if (collision_state != 2'b01) x_acc <= x_cand;
                        goal    <= collision_state == 2'b11;
                        probe_x <= collision_state == 2'b01 ? x_acc : x_cand;
                        probe_y <= y_cand;
                        state   <= need_y ? PROBE_Y : COMMIT;
                    end
                end
                // Entered from PROBE_X with valid low: raise it one cycle later.
                PROBE_Y: if (!probe_valid) probe_valid <= 1'b1;
                else if (probe_ack) begin
                    probe_valid <= 1'b0;
                    case (collision_state)
                        2'b00: begin
                            y_acc    <= y_cand;
                            grounded <= 1'b0;
                            state    <= COMMIT;
                        end
                        2'b01: begin
                            vy <= 5'sd0;
                            if (vy > 5'sd0) grounded <= 1'b1;
                            state <= COMMIT;
                        end
                        2'b10: begin
                            state      <= DEAD;
                            blue_state <= 3'd5;
                        end
                        default: begin
                            y_acc <= y_cand;
                            goal  <= 1'b1;
                            state <= COMMIT;
                        end
                    endcase
                end
                COMMIT: begin
                    x_blue      <= x_acc;
                    y_blue      <= y_acc;
                    update_done <= 1'b1;
                    blue_state  <= goal ? 3'd6 : !grounded ? (vy < 5'sd0 ? 3'd3 : 3'd4)
                                 : dir_l ? 3'd1 : dir_r ? 3'd2 : 3'd0;
                    state       <= goal ? WIN : IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed frames against a behavioural motion model with an
// auto-responding collision checker and a per-cycle output comparator.
module tb_move_sequencer;
    logic       clk = 1'b0, clrn = 1'b0, frame_tick = 1'b0, restart = 1'b0, probe_ack = 1'b0;
    logic [3:0] wsad_down = 4'b0;
    logic [1:0] collision_state = 2'b0;
    logic       probe_valid, update_done, overrun;
    logic [9:0] probe_x, x_blue;
    logic [8:0] probe_y, y_blue;
    logic [2:0] blue_state;

    move_sequencer dut (
        .clk(clk), .clrn(clrn), .frame_tick(frame_tick), .wsad_down(wsad_down),
        .restart(restart), .probe_valid(probe_valid), .probe_x(probe_x), .probe_y(probe_y),
        .probe_ack(probe_ack), .collision_state(collision_state), .x_blue(x_blue),
        .y_blue(y_blue), .blue_state(blue_state), .update_done(update_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int s;} commit_t;

    int checks = 0, failures = 0;
    int lat = 1, rx = 0, ry = 0, flr = 1000;
    bit auto_ack = 1'b0, chk_en = 1'b0, exp_ovr = 1'b0;
    int obs_x[$], obs_y[$];
    commit_t pend[$];
    int cur_x = 40, cur_y = 400, ncommit = 0;
    int m_x = 40, m_y = 400, m_vy = 0;
    bit m_g = 1'b1;
    int jy[18] = '{392, 385, 379, 374, 370, 367, 365, 364, 364, 365, 367, 370, 374, 379, 385, 392, 400, 400};
    int js[18] = '{3, 3, 3, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // Collision checker: X probes keep the committed y; Y probes are solid below the floor.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_ack) begin
                if (probe_valid) begin
                    cnt++;
                    if (cnt == lat) begin
                        probe_ack = 1'b1;
                        obs_x.push_back(int'(probe_x));
                        obs_y.push_back(int'(probe_y));
                        collision_state = (probe_y == y_blue) ? 2'(rx) : (int'(probe_y) > flr) ? 2'd1 : 2'(ry);
                    end else probe_ack = 1'b0;
                end else begin
                    cnt = 0;
                    probe_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        commit_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (update_done) begin
                    if (pend.size() == 0) chk("unexpected_update_done", 1, 0);
                    else begin
                        e = pend.pop_front();
                        chk("commit_x", x_blue, e.x);
                        chk("commit_y", y_blue, e.y);
                        chk("commit_state", blue_state, e.s);
                        cur_x = e.x;
                        cur_y = e.y;
                    end
                    ncommit++;
                end else begin
                    chk("hold_x", x_blue, cur_x);
                    chk("hold_y", y_blue, cur_y);
                end
                chk("overrun", overrun, exp_ovr);
            end
        end
    end

    task automatic frame(input logic [3:0] k, input int rx_, input int ry_, input int flr_);
        int dx, xc, yc, nx, ny, st, r, nc0;
        bit dead, goal, done;
        int ep_x[$], ep_y[$];
        rx = rx_; ry = ry_; flr = flr_;
        dx = (k[0] && !k[1]) ? 2 : (k[1] && !k[0]) ? -2 : 0;
        m_vy = (k[3] && m_g) ? -8 : (m_vy + 1 > 8 ? 8 : m_vy + 1);
        xc = clamp(m_x + dx, 0, 619);
        yc = clamp(m_y + m_vy, 0, 459);
        nx = m_x; ny = m_y; dead = 0; goal = 0;
        if (xc != m_x) begin
            ep_x.push_back(xc); ep_y.push_back(m_y);
            if (rx_ == 2) dead = 1;
            else begin
                if (rx_ != 1) nx = xc;
                if (rx_ == 3) goal = 1;
            end
        end
        if (!dead && m_vy != 0 && yc != m_y) begin
            ep_x.push_back(nx); ep_y.push_back(yc);
            r = yc > flr_ ? 1 : ry_;
            if (r == 0) begin ny = yc; m_g = 0; end
            else if (r == 1) begin if (m_vy > 0) m_g = 1; m_vy = 0; end
            else if (r == 2) dead = 1;
            else begin ny = yc; goal = 1; end
        end
        st = dead ? 5 : goal ? 6 : !m_g ? (m_vy < 0 ? 3 : 4) : dx < 0 ? 1 : dx > 0 ? 2 : 0;
        if (!dead) pend.push_back('{nx, ny, st});
        obs_x.delete(); obs_y.delete();
        nc0 = ncommit;
        wsad_down = k;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (dead ? blue_state == 3'd5 : ncommit != nc0) break;
            @(negedge clk);
        end
        done = dead ? blue_state == 3'd5 : ncommit != nc0;
        chk("frame_done", done, 1);
        @(posedge clk); #1;
        chk("probe_count", obs_x.size(), ep_x.size());
        for (int i = 0; i < ep_x.size() && i < obs_x.size(); i++) begin
            chk("probe_x", obs_x[i], ep_x[i]);
            chk("probe_y", obs_y[i], ep_y[i]);
        end
        chk("frame_state", blue_state, st);
        m_x = nx; m_y = ny;
    endtask

    task automatic ignored_tick();
        obs_x.delete();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("ignored_probes", obs_x.size(), 0);
        chk("ignored_valid", probe_valid, 0);
    endtask

    task automatic model_init();
        m_x = 40; m_y = 400; m_vy = 0; m_g = 1;
        cur_x = 40; cur_y = 400; exp_ovr = 0;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        model_init();
        chk("restart_x", x_blue, 40);
        chk("restart_y", y_blue, 400);
        chk("restart_state", blue_state, 0);
        chk("restart_valid", probe_valid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_x", x_blue, 40);
        chk("reset_y", y_blue, 400);
        chk("reset_state", blue_state, 0);
        chk("reset_valid", probe_valid, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_done", update_done, 0);
        chk_en = 1'b1;
        auto_ack = 1'b1;

        lat = 2;
        begin
            int n0;
            n0 = ncommit;
            repeat (3) frame(4'b0001, 0, 0, 400);
            chk("walk_commits", ncommit - n0, 3);
        end
        chk("walk_x", x_blue, 46);
        chk("walk_y", y_blue, 400);
        chk("walk_state", blue_state, 2);
        frame(4'b0011, 0, 0, 400);
        chk("both_keys_state", blue_state, 0);

        lat = 1;
        frame(4'b1000, 0, 0, 400);
        chk("jump_y0", y_blue, jy[0]);
        chk("jump_s0", blue_state, js[0]);
        for (int i = 1; i < 18; i++) begin
            frame(4'b0000, 0, 0, 400);
            chk("jump_y", y_blue, jy[i]);
            chk("jump_s", blue_state, js[i]);
        end

        frame(4'b1000, 0, 1, 400);
        chk("ceiling_y", y_blue, 400);
        chk("ceiling_state", blue_state, 0);
        frame(4'b0000, 0, 0, 400);

        while (m_x < 619) frame(4'b0001, 0, 0, 400);
        frame(4'b0001, 0, 0, 400);
        chk("xmax_x", x_blue, 619);
        chk("xmax_probes", obs_x.size(), 1);
        while (m_x > 1) frame(4'b0010, 0, 0, 400);
        chk("left_x1", x_blue, 1);
        frame(4'b0010, 0, 0, 400);
        chk("clamp_probe_x", obs_x[0], 0);
        chk("clamp_x0", x_blue, 0);
        frame(4'b0010, 0, 0, 400);
        chk("clamp_skip_probes", obs_x.size(), 1);
        chk("clamp_stay_x", x_blue, 0);
        chk("clamp_state", blue_state, 1);

        frame(4'b0001, 2, 0, 400);
        chk("dead_state", blue_state, 5);
        chk("dead_x", x_blue, 0);
        ignored_tick();
        chk("dead_still", blue_state, 5);
        do_restart();

        frame(4'b0001, 3, 0, 400);
        chk("win_state", blue_state, 6);
        chk("win_x", x_blue, 42);
        ignored_tick();
        do_restart();

        auto_ack = 1'b0;
        probe_ack = 1'b0;
        wsad_down = 4'b0001;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk("hold_valid", probe_valid, 1);
        chk("hold_probe_x", probe_x, 42);
        chk("hold_probe_y", probe_y, 400);
        repeat (2) @(posedge clk);
        #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        exp_ovr = 1'b1;
        chk("overrun_set", overrun, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_sticky", overrun, 1);
        chk("still_valid", probe_valid, 1);
        restart = 1'b1; probe_ack = 1'b1; collision_state = 2'b10; frame_tick = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0; probe_ack = 1'b0; frame_tick = 1'b0;
        model_init();
        chk("rs_valid", probe_valid, 0);
        chk("rs_state", blue_state, 0);
        chk("rs_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rs_idle_valid", probe_valid, 0);

        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk("pre_reset_valid", probe_valid, 1);
        #2;
        clrn = 1'b0;
        #1;
        chk("async_drop_valid", probe_valid, 0);
        probe_ack = 1'b1;
        collision_state = 2'b10;
        @(posedge clk); #1;
        clrn = 1'b1;
        @(posedge clk); #1;
        probe_ack = 1'b0;
        model_init();
        repeat (2) @(posedge clk);
        #1;
        chk("late_ack_valid", probe_valid, 0);
        chk("late_ack_state", blue_state, 0);
        chk("late_ack_x", x_blue, 40);

        chk("pending_empty", pend.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
